// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS control sequencer with bounded memory waits and illegal-opcode trap.
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter behind instr_count.
module multicycle_control_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             Branch,
  output logic             bne,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUOp,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [1:0]       mem_size,
  output logic             mem_unsigned,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, WB_R = 4'd3, ADDR = 4'd4, MEM_RD = 4'd5,
    WB_MEM = 4'd6, MEM_WR = 4'd7, BRANCH = 4'd8, EXEC_I = 4'd9, WB_I = 4'd10, TRAP = 4'd11
  } state_t;
  state_t st, nxt, dec_nxt;
  logic [5:0] op_q;
  logic [WAIT_W-1:0] wcnt;
  logic trap_mem, timeout;
  logic [1:0] op_size;
  assign timeout = wcnt == WAIT_W'(MAX_WAIT);
  assign op_size = (op_q[1:0] == 2'b11) ? 2'b10 : op_q[1:0];
  assign state = st;
  always_comb begin
    dec_nxt = TRAP;
    case (opcode)
      6'b000000: dec_nxt = EXEC_R;
      6'b000100, 6'b000101: dec_nxt = BRANCH;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: dec_nxt = ADDR;
      6'b001100, 6'b001101, 6'b001010, 6'b001011: dec_nxt = EXEC_I;
      default: dec_nxt = TRAP;
    endcase
  end
  // mem_ready takes priority over an expiring wait in the same cycle
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH: nxt = mem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE: nxt = dec_nxt;
      EXEC_R: nxt = WB_R;
      ADDR: nxt = op_q[3] ? MEM_WR : MEM_RD;
      MEM_RD: nxt = mem_ready ? WB_MEM : timeout ? TRAP : MEM_RD;
      MEM_WR: nxt = mem_ready ? FETCH : timeout ? TRAP : MEM_WR;
      EXEC_I: nxt = WB_I;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      wcnt <= '0;
      trap_mem <= 1'b0;
      op_q <= '0;
    end else begin
      st <= nxt;
      wcnt <= (nxt == st) ? wcnt + 1'b1 : '0;
      if (st == DECODE) op_q <= opcode;
      if (nxt == TRAP) trap_mem <= st != DECODE;
    end
  end
  always_comb begin
    RegDst = 1'b0;
    Branch = 1'b0;
    bne = 1'b0;
    MemRead = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc = 1'b0;
    RegWrite = 1'b0;
    ALUOp = 3'b000;
    PCWrite = 1'b0;
    IRWrite = 1'b0;
    mem_size = 2'b00;
    mem_unsigned = 1'b0;
    illegal_op = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          mem_size = 2'b10;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        EXEC_R: ALUOp = 3'b010;
        WB_R: begin
          RegDst = 1'b1;
          RegWrite = 1'b1;
        end
        ADDR: ALUSrc = 1'b1;
        MEM_RD: begin
          MemRead = 1'b1;
          mem_size = op_size;
          mem_unsigned = op_q[2];
        end
        WB_MEM: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          mem_size = op_size;
        end
        BRANCH: begin
          Branch = 1'b1;
          ALUOp = 3'b001;
          bne = op_q[0];
        end
        EXEC_I: begin
          ALUSrc = 1'b1;
          ALUOp = (op_q == 6'b001100) ? 3'b011 : (op_q == 6'b001101) ? 3'b100 :
                  (op_q == 6'b001010) ? 3'b101 : 3'b110;
        end
        WB_I: begin
          ALUSrc = 1'b1;
          RegWrite = 1'b1;
        end
        TRAP: begin
          illegal_op = !trap_mem;
          mem_timeout = trap_mem;
        end
        default: ;
      endcase
    end
  end
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic retire;
  assign retire = (st == WB_R) || (st == WB_MEM) || (st == WB_I) || (st == BRANCH) ||
                  (st == MEM_WR && mem_ready);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (retire) cnt <= cnt + 1'b1;
  end
  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-cycle vector table plus hand sequences for waits, timeouts and reset.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic RegDst, Branch, bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, PCWrite, IRWrite;
  logic mem_unsigned, illegal_op, mem_timeout;
  logic [2:0] ALUOp;
  logic [1:0] mem_size;
  logic [3:0] state;
  logic [31:0] instr_count;
  int checks = 0;
  int failures = 0;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // {RegDst,Branch,bne,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp,PCWrite,IRWrite,mem_size,mem_unsigned,illegal_op,mem_timeout}
  localparam logic [17:0] Z      = 18'b0;
  localparam logic [17:0] F_RDY  = 18'b0_0_0_1_0_0_0_0_000_1_1_10_0_0_0;
  localparam logic [17:0] F_WAIT = 18'b0_0_0_1_0_0_0_0_000_0_0_10_0_0_0;
  localparam logic [17:0] ER     = 18'b0_0_0_0_0_0_0_0_010_0_0_00_0_0_0;
  localparam logic [17:0] WR     = 18'b1_0_0_0_0_0_0_1_000_0_0_00_0_0_0;
  localparam logic [17:0] AD     = 18'b0_0_0_0_0_0_1_0_000_0_0_00_0_0_0;
  localparam logic [17:0] RD_W   = 18'b0_0_0_1_0_0_0_0_000_0_0_10_0_0_0;
  localparam logic [17:0] RD_HU  = 18'b0_0_0_1_0_0_0_0_000_0_0_01_1_0_0;
  localparam logic [17:0] WM     = 18'b0_0_0_0_1_0_0_1_000_0_0_00_0_0_0;
  localparam logic [17:0] ST_B   = 18'b0_0_0_0_0_1_0_0_000_0_0_00_0_0_0;
  localparam logic [17:0] ST_W   = 18'b0_0_0_0_0_1_0_0_000_0_0_10_0_0_0;
  localparam logic [17:0] BNE    = 18'b0_1_1_0_0_0_0_0_001_0_0_00_0_0_0;
  localparam logic [17:0] BEQ    = 18'b0_1_0_0_0_0_0_0_001_0_0_00_0_0_0;
  localparam logic [17:0] EI_OR  = 18'b0_0_0_0_0_0_1_0_100_0_0_00_0_0_0;
  localparam logic [17:0] WI     = 18'b0_0_0_0_0_0_1_1_000_0_0_00_0_0_0;
  localparam logic [17:0] ILL    = 18'b0_0_0_0_0_0_0_0_000_0_0_00_0_1_0;
  localparam logic [17:0] TMO    = 18'b0_0_0_0_0_0_0_0_000_0_0_00_0_0_1;
  typedef struct {
    logic rst;
    logic [5:0] op;
    logic rdy;
    logic [3:0] st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;
  typedef struct {
    int id;
    logic [3:0] st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int vid = 0;
  logic [17:0] act_ctl;
  assign act_ctl = {RegDst, Branch, bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
                    PCWrite, IRWrite, mem_size, mem_unsigned, illegal_op, mem_timeout};
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .RegDst(RegDst), .Branch(Branch), .bne(bne), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (state !== e.st || act_ctl !== e.ctl || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL vec%0d got state=%0d ctl=%b cnt=%0d want state=%0d ctl=%b cnt=%0d",
                 e.id, state, act_ctl, instr_count, e.st, e.ctl, e.cnt);
      end
    end
  end
  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [17:0] ctl, input int cnt);
    tbl.push_back('{r, op, rdy, st, ctl, 32'(cnt)});
  endtask
  task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [17:0] ctl, input int cnt);
    @(posedge clk);
    #1;
    reset = r;
    opcode = op;
    mem_ready = rdy;
    sb.push_back('{vid, st, ctl, PERF ? 32'(cnt) : 32'd0});
    vid++;
  endtask
  task automatic rst_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
  endtask
  initial begin
    add(1, 6'o00, 0, 0, Z, 0);
    add(0, 6'b000000, 1, 0, F_RDY, 0);
    add(0, 6'b000000, 1, 1, Z, 0);
    add(0, 6'b000000, 1, 2, ER, 0);
    add(0, 6'b000000, 1, 3, WR, 0);
    add(0, 6'b100011, 1, 0, F_RDY, 1);
    add(0, 6'b100011, 1, 1, Z, 1);
    add(0, 6'b100011, 1, 4, AD, 1);
    add(0, 6'b100011, 0, 5, RD_W, 1);
    add(0, 6'b100011, 0, 5, RD_W, 1);
    add(0, 6'b100011, 1, 5, RD_W, 1);
    add(0, 6'b100011, 1, 6, WM, 1);
    add(0, 6'b100101, 1, 0, F_RDY, 2);
    add(0, 6'b100101, 1, 1, Z, 2);
    add(0, 6'b100101, 1, 4, AD, 2);
    add(0, 6'b100101, 1, 5, RD_HU, 2);
    add(0, 6'b100101, 1, 6, WM, 2);
    add(0, 6'b101000, 1, 0, F_RDY, 3);
    add(0, 6'b101000, 1, 1, Z, 3);
    add(0, 6'b101000, 1, 4, AD, 3);
    add(0, 6'b101000, 1, 7, ST_B, 3);
    add(0, 6'b000101, 1, 0, F_RDY, 4);
    add(0, 6'b000101, 1, 1, Z, 4);
    add(0, 6'b000101, 1, 8, BNE, 4);
    add(0, 6'b001101, 1, 0, F_RDY, 5);
    add(0, 6'b001101, 1, 1, Z, 5);
    add(0, 6'b001101, 1, 9, EI_OR, 5);
    add(0, 6'b001101, 1, 10, WI, 5);
    add(0, 6'b111111, 1, 0, F_RDY, 6);
    add(0, 6'b111111, 1, 1, Z, 6);
    add(0, 6'b111111, 1, 11, ILL, 6);
    add(0, 6'b101011, 1, 0, F_RDY, 6);
    add(0, 6'b101011, 1, 1, Z, 6);
    add(0, 6'b101011, 1, 4, AD, 6);
    add(0, 6'b101011, 0, 7, ST_W, 6);
    add(0, 6'b101011, 1, 7, ST_W, 6);
    add(0, 6'b000100, 0, 0, F_WAIT, 7);
    add(0, 6'b000100, 1, 0, F_RDY, 7);
    add(0, 6'b000100, 1, 1, Z, 7);
    add(0, 6'b000100, 1, 8, BEQ, 7);
    add(0, 6'b000000, 0, 0, F_WAIT, 8);
    rst_cycle();
    rst_cycle();
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctl, int'(tbl[i].cnt));
    // FETCH timeout: 16 waiting cycles then TRAP with mem_timeout
    rst_cycle();
    for (int i = 0; i < 16; i++) step(0, 6'b000000, 0, 0, F_WAIT, 0);
    step(0, 6'b000000, 0, 11, TMO, 0);
    step(0, 6'b000000, 1, 0, F_RDY, 0);
    // ready arriving on the last allowed cycle wins over the trap
    rst_cycle();
    for (int i = 0; i < 15; i++) step(0, 6'b100011, 0, 0, F_WAIT, 0);
    step(0, 6'b100011, 1, 0, F_RDY, 0);
    step(0, 6'b100011, 1, 1, Z, 0);
    step(0, 6'b100011, 0, 4, AD, 0);
    for (int i = 0; i < 16; i++) step(0, 6'b100011, 0, 5, RD_W, 0);
    step(0, 6'b100011, 0, 11, TMO, 0);
    step(0, 6'b100011, 1, 0, F_RDY, 0);
    step(0, 6'b000100, 1, 1, Z, 0);
    step(0, 6'b000100, 1, 8, BEQ, 0);
    step(0, 6'b100011, 1, 0, F_RDY, 1);
    // reset in MEM_RD abandons the load and clears the counter
    step(0, 6'b100011, 1, 1, Z, 1);
    step(0, 6'b100011, 1, 4, AD, 1);
    step(0, 6'b100011, 0, 5, RD_W, 1);
    step(1, 6'b100011, 1, 5, Z, 1);
    step(0, 6'b100011, 0, 0, F_WAIT, 0);
    step(0, 6'b100011, 0, 0, F_WAIT, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle successor to the single-cycle MIPS main control decoder. The decoder is replaced by a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles. Memory accesses are stretched by a ready handshake with a bounded wait, and the block traps illegal opcodes. It sits between the instruction register/memory interface and the datapath, driving the same control signals as the single-cycle unit plus the multicycle enables.

## Interface
- MAX_WAIT, 15, maximum consecutive cycles a memory state waits for mem_ready before trapping
- WAIT_W, 4, width of the wait counter (must hold MAX_WAIT)
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26], valid from the DECODE cycle, latched internally in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- RegDst, Branch, bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath controls
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 sltu
- PCWrite, IRWrite  out  1  PC+4 update / instruction register load
- mem_size  out  2  00 byte, 01 half, 10 word
- mem_unsigned  out  1  zero-extend the load (lbu/lhu)
- state  out  4  current state encoding
- illegal_op, mem_timeout  out  1  one-cycle trap flags
- instr_count  out  CNT_W  retired instructions (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, BRANCH=8, EXEC_I=9, WB_I=10, TRAP=11.
- FETCH: MemRead=1, mem_size=10. On mem_ready: IRWrite=1, PCWrite=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode. Next state by opcode:
  - 000000 goes to EXEC_R.
  - 000100/000101 go to BRANCH.
  - 100000/100001/100011/100100/100101 go to ADDR.
  - 101000/101001/101011 go to ADDR.
  - 001100/001101/001010/001011 go to EXEC_I.
  - Any other opcode goes to TRAP.
- EXEC_R: ALUOp=010. Then WB_R: RegDst=1, RegWrite=1, then FETCH.
- ADDR: ALUSrc=1, ALUOp=000. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD: MemRead=1. mem_size/mem_unsigned come from the latched opcode (lb/lbu 00, lh/lhu 01, lw 10). On mem_ready go to WB_MEM: MemtoReg=1, RegWrite=1, then FETCH.
- MEM_WR: MemWrite=1. mem_size comes from sb/sh/sw. On mem_ready go to FETCH.
- BRANCH: Branch=1, ALUOp=001, bne=1 only for 000101. Then FETCH.
- EXEC_I: ALUSrc=1, ALUOp is andi 011, ori 100, slti 101, sltiu 110. Then WB_I: ALUSrc=1, RegWrite=1, RegDst=0, then FETCH.
- TRAP: pulse illegal_op (if entered from DECODE) or mem_timeout (if entered from a memory state), then FETCH.
- Every output not listed for a state is 0.
- Wait counter:
  - Counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on any state change.
  - When it equals MAX_WAIT and mem_ready=0, go to TRAP.
  - If mem_ready=1 in that same cycle, mem_ready wins and no trap occurs.

## Timing
- Outputs are a Moore decode of the state register and the latched opcode. Exception: IRWrite/PCWrite in FETCH also require mem_ready.
- Latency with zero wait states: R-type 4, I-type ALU 4, load 5, store 4, branch 3, illegal 3 cycles (FETCH through return to FETCH).
- Each memory cycle with mem_ready low adds one cycle.
- A timed-out access occupies MAX_WAIT+1 cycles in the memory state, then one cycle in TRAP.
- Reset: on the next edge, state becomes FETCH and the wait counter clears. While reset is high, all control outputs, flags and ALUOp are forced to 0.
- Reset mid-instruction abandons the instruction; it is not counted.
- The first fetch occurs in the first cycle after reset falls.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - instr_count increments by 1 on the edge leaving WB_R, WB_MEM, WB_I, BRANCH, or MEM_WR with mem_ready.
  - TRAP exits do not count.
  - The counter clears on reset and wraps modulo 2^CNT_W.
- CTRL_PERF_CNT_EN undefined: instr_count is tied to 0 and no counter logic exists.

## Test plan
- Reset then opcode 000000, mem_ready=1 always: state sequence 0,1,2,3,0. WB_R shows RegDst=1, RegWrite=1. instr_count=1 (macro on).
- lw 100011, mem_ready low 2 cycles in MEM_RD: sequence 0,1,4,5,5,5,6,0. mem_size=10 throughout MEM_RD. Total 7 cycles.
- lhu 100101 then sb 101000: lhu shows mem_size=01, mem_unsigned=1. sb shows MemWrite=1, mem_size=00, RegWrite=0.
- bne 000101: BRANCH shows Branch=1, bne=1, ALUOp=001. Returns to FETCH after 3 cycles.
- Opcode 111111: goes to TRAP after DECODE, illegal_op high exactly 1 cycle, instr_count unchanged.
- mem_ready held 0 in FETCH with MAX_WAIT=15: 16 FETCH cycles, then TRAP with mem_timeout=1. Repeat with mem_ready=1 in the 16th cycle: goes to DECODE, no trap. Reset asserted in MEM_RD: FETCH next cycle, all outputs 0 while reset is high.
